// File: rtl/tl_traffic_sensor_if.sv
// Street-side bundle between the detectors, the light controller and the traffic sensor.
// The master drives the detector levels and light codes; the slave returns the queue state.
interface tl_traffic_sensor_if #(
  parameter int CNT_W = 4
);
  logic             car_a;
  logic             car_b;
  logic [1:0]       La;
  logic [1:0]       Lb;
  logic             Ta;
  logic             Tb;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             ovf_a;
  logic             ovf_b;

  modport master (
    output car_a, car_b, La, Lb,
    input  Ta, Tb, cnt_a, cnt_b, ovf_a, ovf_b
  );

  modport slave (
    input  car_a, car_b, La, Lb,
    output Ta, Tb, cnt_a, cnt_b, ovf_a, ovf_b
  );
endinterface

// File: rtl/tl_traffic_sensor.sv
// Traffic sensor: counts detector rising edges into per-street queues and drains
// the queue of whichever street is green at one vehicle per DEPART_CYCLES clocks.
module tl_traffic_sensor #(
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  tl_traffic_sensor_if.slave   sens
);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0]       TMR_LAST = 8'(DEPART_CYCLES - 1);

  // Index 0 is street A, index 1 is street B; both streets are identical.
  logic [1:0]            car;
  logic [1:0]            green;
  logic [1:0]            det_q;
  logic [1:0][7:0]       tmr;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0]            ovf;
  logic [1:0]            arr;
  logic [1:0]            run;
  logic [1:0]            dep;

  assign car   = {sens.car_b, sens.car_a};
  assign green = {(sens.Lb == 2'b00), (sens.La == 2'b00)};

  always_comb begin
    arr = '0;
    run = '0;
    dep = '0;
    for (int i = 0; i < 2; i++) begin
      arr[i] = car[i] & ~det_q[i];
      run[i] = green[i] & (cnt[i] != '0);
      dep[i] = run[i] & (tmr[i] == TMR_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      det_q <= 2'b11;  // a detector held high through reset is not an arrival
      tmr   <= '0;
      cnt   <= '0;
      ovf   <= '0;
    end else begin
      det_q <= car;
      for (int i = 0; i < 2; i++) begin
        if (!run[i] || dep[i])
          tmr[i] <= 8'd0;
        else
          tmr[i] <= tmr[i] + 8'd1;

        if (arr[i] && !dep[i]) begin
          if (cnt[i] == CNT_MAX)
            ovf[i] <= 1'b1;
          else
            cnt[i] <= cnt[i] + 1'b1;
        end else if (dep[i] && !arr[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  assign sens.cnt_a = cnt[0];
  assign sens.cnt_b = cnt[1];
  assign sens.ovf_a = ovf[0];
  assign sens.ovf_b = ovf[1];
  assign sens.Ta    = (cnt[0] != '0);
  assign sens.Tb    = (cnt[1] != '0);
endmodule

// File: doc/tl_traffic_sensor.md
Name: tl_traffic_sensor

Overview:
- Models the street side of the traffic light controller: turns vehicle-detector levels into queue counts and drives the controller's traffic-present inputs Ta/Tb.
- Takes the controller's La/Lb light codes back in. While a street is green, it drains that street's queue at a fixed rate.
- Sits between the detector inputs and tl_cntr. Used both as the real sensor front end and as a closed-loop stimulus source for controller benches.

Parameters:
- CNT_W, 4: width of each queue counter; max count 2^CNT_W-1.
- DEPART_CYCLES, 3: clock cycles per vehicle departure while green; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high, sampled on rising clk.
- car_a  input  1  street A detector level; each rising edge is one arrival.
- car_b  input  1  street B detector level; each rising edge is one arrival.
- La  input  2  street A light from controller: 00 green, 01 yellow, 10 red, 11 treated as red.
- Lb  input  2  street B light, same encoding as La.
- Ta  output  1  street A traffic present: (cnt_a != 0).
- Tb  output  1  street B traffic present: (cnt_b != 0).
- cnt_a  output  CNT_W  street A queue length.
- cnt_b  output  CNT_W  street B queue length.
- ovf_a  output  1  sticky: a street A arrival was lost at saturation.
- ovf_b  output  1  sticky: a street B arrival was lost at saturation.

Behaviour:
- Reset, while reset=1 at a clk edge:
  - cnt_a, cnt_b, ovf_a, ovf_b and both departure timers go to 0.
  - Both detector history registers go to 1, so a detector held high through reset is not counted.
  - Ta=Tb=0 in the cycle after reset.
  - Reset mid-operation discards queued vehicles immediately; no departures are emitted.
- Street A and street B are identical and independent; street A is described below.
- Arrival detection:
  - det_a_q registers car_a every clock.
  - arr_a = car_a & ~det_a_q, evaluated in cycle N. A level held high counts once.
- Departure timer tmr_a:
  - Width is 8 bits, enough for 255.
  - Runs only while La==00 and cnt_a!=0; otherwise it is forced to 0 on the next edge.
  - When running and tmr_a==DEPART_CYCLES-1: dep_a=1 in that cycle and tmr_a returns to 0; otherwise tmr_a increments.
  - With DEPART_CYCLES=1, dep_a=1 every running cycle.
  - The first departure comes DEPART_CYCLES cycles after green is seen with a non-empty queue.
  - Yellow (01), red (10) and 11 all stop departures and clear the timer; the remaining count holds.
- Counter update at the clock edge ending cycle N:
  - arr only: cnt+1. If cnt is already at max, it holds and ovf is set.
  - dep only: cnt-1. dep is never asserted when cnt==0.
  - arr and dep in the same cycle: cnt unchanged, ovf unchanged, even at max.
  - Neither: hold.
- ovf_a is sticky until reset.
- Ta/Tb are combinational from the registered counts.
  - Ta rises in cycle N+1 after an arrival edge in cycle N.
  - Ta falls in the cycle after the last departure edge.
- All outputs are glitch-free functions of registers; no combinational path exists from La/car_a to any output.

Test Plan:
- Reset with car_a=1 held, release, La=10 → cnt_a stays 0, Ta=0. Drop car_a, raise it again → cnt_a=1 and Ta=1 one cycle after the rising edge.
- Three car_b pulses (2 cycles high, 2 low) with Lb=10 → cnt_b=3, Tb=1. Hold 20 cycles → cnt_b still 3.
- cnt_a=2, La switches 10→00 with DEPART_CYCLES=3 → cnt_a=1 after 3 cycles, 0 after 6 cycles. Ta falls the cycle after; timer then stays 0.
- cnt_a=2, La=00 for 2 cycles, then 01 → no departure, timer cleared. Back to 00 → the next departure needs a full 3 cycles.
- CNT_W=2, 4 arrivals on red → cnt_a=3 and ovf_a=1. On green, a departure and an arrival edge in the same cycle → cnt_a stays 3, ovf_a stays 1.
- Closed loop with tl_cntr, car_a and car_b toggling → Ta/Tb track the queues, both queues eventually drain to 0, and the light sequence alternates.
